// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard unit with memory-wait hold, flush/stall priority and stall/timeout counters.
// Define HAZARD_FORWARD_EN to add EX operand forwarding (stalls then only on load-use).
module hazard_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rt,
  input  logic [4:0]  ex_rs,
  input  logic [4:0]  ex_rt,
  input  logic [4:0]  ex_dst,
  input  logic        ex_regwrite,
  input  logic        ex_memread,
  input  logic [4:0]  mem_dst,
  input  logic        mem_regwrite,
  input  logic [4:0]  wb_dst,
  input  logic        wb_regwrite,
  input  logic        ex_branch_taken,
  input  logic        id_jump,
  input  logic        mem_req,
  input  logic        mem_ack,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        if_id_flush,
  output logic        id_ex_bubble,
  output logic        pipe_hold,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic [15:0] stall_count,
  output logic        mem_timeout
);
  typedef enum logic {RUN, MEM_WAIT} state_t;
  state_t state, state_n;
  logic [7:0] wait_cnt;
  logic miss, hold, raw;
  logic [1:0] fa, fb;
  logic unused_ok;
  function automatic logic hit(input logic [4:0] d, input logic [4:0] rs, input logic [4:0] rt, input logic urt);
    return (d != 5'd0) && (d == rs || (urt && d == rt));
  endfunction
`ifdef HAZARD_FORWARD_EN
  function automatic logic [1:0] fsel(input logic [4:0] r);
    return (r == 5'd0) ? 2'b00 : (mem_regwrite && mem_dst == r) ? 2'b10 : (wb_regwrite && wb_dst == r) ? 2'b01 : 2'b00;
  endfunction
  assign raw = ex_memread && hit(ex_dst, id_rs, id_rt, id_uses_rt);
  assign fa = fsel(ex_rs);
  assign fb = fsel(ex_rt);
  assign unused_ok = ex_regwrite;
`else
  // The regfile writes before it reads, so WB never needs a stall.
  assign raw = (ex_regwrite && hit(ex_dst, id_rs, id_rt, id_uses_rt)) || (mem_regwrite && hit(mem_dst, id_rs, id_rt, id_uses_rt));
  assign fa = 2'b00;
  assign fb = 2'b00;
  assign unused_ok = ^{ex_rs, ex_rt, ex_memread, wb_dst, wb_regwrite};
`endif
  assign miss = mem_req && !mem_ack;
  assign hold = (state == MEM_WAIT) || miss;
  always_comb begin
    state_n = state;
    pc_write = 1'b1;
    if_id_write = 1'b1;
    if_id_flush = 1'b0;
    id_ex_bubble = 1'b0;
    pipe_hold = 1'b0;
    fwd_a = rst ? 2'b00 : fa;
    fwd_b = rst ? 2'b00 : fb;
    if (!rst) begin
      state_n = (state == MEM_WAIT) ? (mem_ack ? RUN : MEM_WAIT) : (miss ? MEM_WAIT : RUN);
      if (hold) begin
        pc_write = 1'b0;
        if_id_write = 1'b0;
        pipe_hold = 1'b1;
      end else if (ex_branch_taken) begin
        if_id_flush = 1'b1;
        id_ex_bubble = 1'b1;
      end else if (raw) begin
        pc_write = 1'b0;
        if_id_write = 1'b0;
        id_ex_bubble = 1'b1;
      end else if (id_jump) begin
        if_id_flush = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      wait_cnt <= 8'd0;
      stall_count <= 16'd0;
      mem_timeout <= 1'b0;
    end else begin
      state <= state_n;
      wait_cnt <= (state == RUN) ? 8'd0 : wait_cnt + {7'd0, wait_cnt != 8'hFF};
      if (state == MEM_WAIT && wait_cnt == 8'd254) mem_timeout <= 1'b1;
      if (!pc_write && stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: vector table, hand sequences and random stimulus against a behavioural model of hazard_ctrl.
module tb_hazard_ctrl;
  typedef struct packed {
    logic [4:0] id_rs, id_rt; logic id_uses_rt;
    logic [4:0] ex_rs, ex_rt, ex_dst; logic ex_regwrite, ex_memread;
    logic [4:0] mem_dst; logic mem_regwrite;
    logic [4:0] wb_dst; logic wb_regwrite;
    logic branch, jump, mem_req, mem_ack;
  } in_t;
  typedef struct packed {
    logic pc, ifid, flush, bubble, hold; logic [1:0] fa, fb;
  } out_t;
  typedef struct { in_t i; out_t o; } vec_t;

  logic clk = 1'b0, rst = 1'b1;
  in_t x = '0;
  logic pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold, mem_timeout;
  logic [1:0] fwd_a, fwd_b;
  logic [15:0] stall_count;
  int n_chk = 0, n_fail = 0;
  bit m_wait, m_to;
  int m_wcyc, m_stalls;

  hazard_ctrl dut (
    .clk(clk), .rst(rst), .id_rs(x.id_rs), .id_rt(x.id_rt), .id_uses_rt(x.id_uses_rt),
    .ex_rs(x.ex_rs), .ex_rt(x.ex_rt), .ex_dst(x.ex_dst), .ex_regwrite(x.ex_regwrite), .ex_memread(x.ex_memread),
    .mem_dst(x.mem_dst), .mem_regwrite(x.mem_regwrite), .wb_dst(x.wb_dst), .wb_regwrite(x.wb_regwrite),
    .ex_branch_taken(x.branch), .id_jump(x.jump), .mem_req(x.mem_req), .mem_ack(x.mem_ack),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble),
    .pipe_hold(pipe_hold), .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_count(stall_count), .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic in_t mk(int rs, int rt, int urt, int ers, int ert, int ed, int erw, int emr,
                             int md, int mrw, int wd, int wrw, int br, int jp, int rq, int ak);
    in_t v;
    v.id_rs = 5'(rs); v.id_rt = 5'(rt); v.id_uses_rt = 1'(urt);
    v.ex_rs = 5'(ers); v.ex_rt = 5'(ert); v.ex_dst = 5'(ed); v.ex_regwrite = 1'(erw); v.ex_memread = 1'(emr);
    v.mem_dst = 5'(md); v.mem_regwrite = 1'(mrw); v.wb_dst = 5'(wd); v.wb_regwrite = 1'(wrw);
    v.branch = 1'(br); v.jump = 1'(jp); v.mem_req = 1'(rq); v.mem_ack = 1'(ak);
    return v;
  endfunction

  function automatic out_t mo(int pc, int ifid, int fl, int bu, int ho, int fa, int fb);
    out_t o;
    o.pc = 1'(pc); o.ifid = 1'(ifid); o.flush = 1'(fl); o.bubble = 1'(bu); o.hold = 1'(ho);
    o.fa = 2'(fa); o.fb = 2'(fb);
    return o;
  endfunction

  // Does an instruction writing register d conflict with the ID instruction's sources?
  function automatic bit reads(int d, in_t v);
    return d != 0 && (d == int'(v.id_rs) || (v.id_uses_rt && d == int'(v.id_rt)));
  endfunction

  function automatic int src(int r, in_t v);
`ifdef HAZARD_FORWARD_EN
    if (r == 0) return 0;
    if (v.mem_regwrite && int'(v.mem_dst) == r) return 2;
    if (v.wb_regwrite && int'(v.wb_dst) == r) return 1;
`endif
    return 0;
  endfunction

  function automatic out_t model(in_t v);
    bit held, stall;
    int fa, fb;
    held = m_wait || (v.mem_req && !v.mem_ack);
`ifdef HAZARD_FORWARD_EN
    stall = v.ex_memread && reads(int'(v.ex_dst), v);
`else
    stall = (v.ex_regwrite && reads(int'(v.ex_dst), v)) || (v.mem_regwrite && reads(int'(v.mem_dst), v));
`endif
    fa = src(int'(v.ex_rs), v);
    fb = src(int'(v.ex_rt), v);
    if (held) return mo(0, 0, 0, 0, 1, fa, fb);
    if (v.branch) return mo(1, 1, 1, 1, 0, fa, fb);
    if (stall) return mo(0, 0, 0, 1, 0, fa, fb);
    if (v.jump) return mo(1, 1, 1, 0, 0, fa, fb);
    return mo(1, 1, 0, 0, 0, fa, fb);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_wait = 0; m_to = 0; m_wcyc = 0; m_stalls = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic step(input in_t v, input out_t e, input string nm);
    x = v;
    #1;
    chk({nm, "_out"}, 32'({pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold, fwd_a, fwd_b}), 32'(e));
    chk({nm, "_stalls"}, 32'(stall_count), 32'(m_stalls));
    chk({nm, "_timeout"}, 32'(mem_timeout), 32'(m_to));
    @(posedge clk);
    if (m_wait) begin
      m_wcyc++;
      if (m_wcyc == 255) m_to = 1;
      if (v.mem_ack) m_wait = 0;
    end else if (v.mem_req && !v.mem_ack) begin
      m_wait = 1;
      m_wcyc = 0;
    end
    if (!e.pc && m_stalls < 65535) m_stalls++;
    @(negedge clk);
  endtask

  initial begin
    vec_t tab[15];
    in_t v;
    bit fw;
`ifdef HAZARD_FORWARD_EN
    fw = 1;
`else
    fw = 0;
`endif
    tab[0]  = '{mk(0,0,1, 0,0,0,1,1, 0,1, 0,1, 0,0,0,0), mo(1,1,0,0,0,0,0)};
    tab[1]  = '{mk(5,0,0, 0,0,5,1,1, 0,0, 0,0, 0,0,0,0), mo(0,0,0,1,0,0,0)};
    tab[2]  = '{mk(1,5,0, 0,0,5,1,1, 0,0, 0,0, 0,0,0,0), mo(1,1,0,0,0,0,0)};
    tab[3]  = '{mk(1,5,1, 0,0,5,1,1, 0,0, 0,0, 0,0,0,0), mo(0,0,0,1,0,0,0)};
    tab[4]  = '{mk(5,0,0, 0,0,5,1,1, 0,0, 0,0, 1,1,0,0), mo(1,1,1,1,0,0,0)};
    tab[5]  = '{mk(5,0,0, 0,0,5,1,1, 0,0, 0,0, 0,1,0,0), mo(0,0,0,1,0,0,0)};
    tab[6]  = '{mk(0,0,0, 0,0,0,0,0, 0,0, 0,0, 0,1,0,0), mo(1,1,1,0,0,0,0)};
    tab[7]  = '{mk(0,0,0, 0,0,0,0,0, 0,0, 0,0, 0,1,1,1), mo(1,1,1,0,0,0,0)};
    tab[8]  = '{mk(4,0,0, 0,0,4,1,0, 0,0, 0,0, 0,0,0,0), fw ? mo(1,1,0,0,0,0,0) : mo(0,0,0,1,0,0,0)};
    tab[9]  = '{mk(0,6,1, 0,0,0,0,0, 6,1, 0,0, 0,0,0,0), fw ? mo(1,1,0,0,0,0,0) : mo(0,0,0,1,0,0,0)};
    tab[10] = '{mk(7,0,0, 0,0,0,0,0, 0,0, 7,1, 0,0,0,0), mo(1,1,0,0,0,0,0)};
    tab[11] = '{mk(0,0,0, 8,8,0,0,0, 8,1, 8,1, 0,0,0,0), fw ? mo(1,1,0,0,0,2,2) : mo(1,1,0,0,0,0,0)};
    tab[12] = '{mk(0,0,0, 0,0,0,0,0, 0,1, 0,1, 0,0,0,0), mo(1,1,0,0,0,0,0)};
    tab[13] = '{mk(0,0,0, 0,9,0,0,0, 3,1, 9,1, 0,0,0,0), fw ? mo(1,1,0,0,0,0,1) : mo(1,1,0,0,0,0,0)};
    tab[14] = '{mk(0,0,0, 3,9,0,0,0, 3,1, 9,1, 0,0,0,0), fw ? mo(1,1,0,0,0,2,1) : mo(1,1,0,0,0,0,0)};

    // Outputs are forced while reset is held, whatever the inputs ask for.
    x = mk(5,0,0, 8,0,5,1,1, 8,1, 0,0, 1,1,1,0);
    #2;
    chk("rst_out", 32'({pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold, fwd_a, fwd_b}), 32'(mo(1,1,0,0,0,0,0)));
    @(posedge clk); #1;
    chk("rst_out_edge", 32'({pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold, fwd_a, fwd_b}), 32'(mo(1,1,0,0,0,0,0)));
    chk("rst_stalls", 32'(stall_count), 32'd0);
    chk("rst_timeout", 32'(mem_timeout), 32'd0);
    @(negedge clk);
    x = '0;
    do_reset();

    for (int i = 0; i < 15; i++) step(tab[i].i, tab[i].o, $sformatf("vec%0d", i));

    do_reset();
    step(mk(5,0,0, 0,0,5,1,1, 0,0, 0,0, 0,0,0,0), mo(0,0,0,1,0,0,0), "loaduse");
    step('0, mo(1,1,0,0,0,0,0), "loaduse_after");
    chk("loaduse_count", 32'(stall_count), 32'd1);

    do_reset();
    step(mk(0,3,1, 0,0,3,1,0, 0,0, 0,0, 0,0,0,0), fw ? mo(1,1,0,0,0,0,0) : mo(0,0,0,1,0,0,0), "raw_ex");
    step(mk(0,3,1, 0,0,0,0,0, 3,1, 0,0, 0,0,0,0), fw ? mo(1,1,0,0,0,0,0) : mo(0,0,0,1,0,0,0), "raw_mem");
    step(mk(0,3,1, 0,0,0,0,0, 0,0, 3,1, 0,0,0,0), mo(1,1,0,0,0,0,0), "raw_wb");
    chk("raw_count", 32'(stall_count), fw ? 32'd0 : 32'd2);

    // Memory wait with a taken branch pending: the flush happens only after the hold drops.
    do_reset();
    for (int i = 0; i < 4; i++) step(mk(0,0,0, 0,0,0,0,0, 0,0, 0,0, 1,0,1,0), mo(0,0,0,0,1,0,0), "memwait");
    step(mk(0,0,0, 0,0,0,0,0, 0,0, 0,0, 1,0,1,1), mo(0,0,0,0,1,0,0), "memwait_ack");
    step(mk(0,0,0, 0,0,0,0,0, 0,0, 0,0, 1,0,0,0), mo(1,1,1,1,0,0,0), "memwait_branch");
    step('0, mo(1,1,0,0,0,0,0), "memwait_run");
    chk("memwait_count", 32'(stall_count), 32'd5);

    do_reset();
    v = mk(0,0,0, 0,0,0,0,0, 0,0, 0,0, 0,0,1,0);
    for (int i = 0; i < 255; i++) step(v, mo(0,0,0,0,1,0,0), "timeout_wait");
    chk("timeout_254", 32'(mem_timeout), 32'd0);
    step(v, mo(0,0,0,0,1,0,0), "timeout_wait");
    chk("timeout_255", 32'(mem_timeout), 32'd1);
    step(v, mo(0,0,0,0,1,0,0), "timeout_stay");
    #2 rst = 1'b1;
    #1;
    chk("async_timeout", 32'(mem_timeout), 32'd0);
    chk("async_stalls", 32'(stall_count), 32'd0);
    chk("async_hold", 32'({pc_write, pipe_hold}), 32'b10);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step('0, mo(1,1,0,0,0,0,0), "after_rst");

    for (int i = 0; i < 400; i++) begin
      v = mk($urandom_range(0,7), $urandom_range(0,7), $urandom_range(0,1),
             $urandom_range(0,7), $urandom_range(0,7), $urandom_range(0,7), $urandom_range(0,1), $urandom_range(0,1),
             $urandom_range(0,7), $urandom_range(0,1), $urandom_range(0,7), $urandom_range(0,1),
             $urandom_range(0,3) == 0, $urandom_range(0,3) == 0, $urandom_range(0,3) == 0, $urandom_range(0,3) != 0);
      step(v, model(v), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001: clk  in  1  pipeline clock; all state updates on rising edge.
REQ-002: rst  in  1  reset, asynchronous, active-high.
REQ-003: id_rs, id_rt  in  5 each  source registers of the instruction in ID; id_uses_rt  in  1  ID instruction reads rt.
REQ-004: ex_rs, ex_rt  in  5 each  source registers held in ID/EX.
REQ-005: ex_dst  in  5  ID/EX destination after RegDst select; ex_regwrite, ex_memread  in  1 each.
REQ-006: mem_dst  in  5  EX/MEM destination; mem_regwrite  in  1.
REQ-007: wb_dst  in  5  MEM/WB destination after link-register select (31 when PctoReg); wb_regwrite  in  1.
REQ-008: ex_branch_taken  in  1  branch resolved taken in EX; id_jump  in  1  jump decoded in ID.
REQ-009: mem_req  in  1  MEM stage accesses data memory; mem_ack  in  1  data memory completes this cycle.
REQ-010: pc_write, if_id_write  out  1 each  enables for PC and IF/ID.
REQ-011: if_id_flush  out  1  zero IF/ID; id_ex_bubble  out  1  zero ID/EX control; pipe_hold  out  1  freeze ID/EX, EX/MEM, MEM/WB.
REQ-012: fwd_a, fwd_b  out  2 each  ALU operand source select: 00 regfile, 10 EX/MEM, 01 MEM/WB.
REQ-013: stall_count  out  16  stall-cycle counter; mem_timeout  out  1  sticky memory-timeout flag.

Function
REQ-014: FSM states: RUN, MEM_WAIT; register $0 never creates a hazard or forward.
REQ-015: RUN with mem_req=1 and mem_ack=0: outputs pc_write=0, if_id_write=0, pipe_hold=1, if_id_flush=0, id_ex_bubble=0 this cycle; next state MEM_WAIT.
REQ-016: MEM_WAIT: same hold outputs every cycle until mem_ack=1; in the mem_ack=1 cycle, hold outputs remain asserted; next state RUN.
REQ-017: mem_req=1 with mem_ack=1 in RUN causes no hold.
REQ-018: Priority when not holding: branch flush > RAW stall > jump flush.
REQ-019: Branch flush: ex_branch_taken=1 -> pc_write=1, if_id_write=1, if_id_flush=1, id_ex_bubble=1 for one cycle.
REQ-020: While held, flush and stall decisions are deferred; held inputs remain stable and are acted on in the first non-held cycle.
REQ-021: RAW stall -> pc_write=0, if_id_write=0, id_ex_bubble=1, if_id_flush=0; one cycle per detection, re-evaluated each cycle.
REQ-022: Jump flush: id_jump=1 and no stall -> if_id_flush=1, pc_write=1.
REQ-023: Regfile writes before reads within a cycle; the WB stage never causes a stall.
REQ-024: MEM_WAIT cycle counter, 8 bits, cleared on entry; at 255, mem_timeout sets and stays set until reset; FSM stays in MEM_WAIT.
REQ-025: stall_count increments every cycle pc_write=0, saturating at 16'hFFFF.

Reset
REQ-026: rst=1 -> state RUN, wait counter 0, stall_count 0, mem_timeout 0, effective immediately regardless of clk.
REQ-027: While rst=1, outputs are forced: pc_write=1, if_id_write=1, if_id_flush=0, id_ex_bubble=0, pipe_hold=0, fwd_a=fwd_b=00.
REQ-028: Reset asserted during MEM_WAIT or a stall aborts it; the first cycle after release is evaluated in RUN.

Configuration
REQ-029: Macro HAZARD_FORWARD_EN defined -> forwarding logic is present.
REQ-030: Forwarding, per operand: mem_regwrite and mem_dst equal to ex_rs/ex_rt -> 10.
REQ-031: Otherwise, wb_regwrite and wb_dst match -> 01; otherwise 00.
REQ-032: With forwarding, a RAW stall occurs only when ex_memread=1 and ex_dst matches id_rs (or id_rt with id_uses_rt).
REQ-033: Macro undefined -> fwd_a=fwd_b=00 constantly.
REQ-034: Without forwarding, a RAW stall occurs when id_rs/used id_rt matches ex_dst with ex_regwrite=1, or mem_dst with mem_regwrite=1.

Verification
REQ-035: FORWARD_EN, ex_memread=1, ex_dst=5, id_rs=5 -> one cycle pc_write=0, id_ex_bubble=1; stall_count=1.
REQ-036: FORWARD_EN, mem_dst=8 and wb_dst=8 both writing, ex_rs=8 -> fwd_a=10; ex_rs=0, mem_dst=0 -> fwd_a=00.
REQ-037: No macro, ex_dst=3 writing, id_rt=3, id_uses_rt=1 -> stall; the next cycle, with the value now in mem_dst=3, stalls again; 2 stall cycles in total.
REQ-038: mem_req=1, mem_ack low 4 cycles then high -> pipe_hold=1 for 5 cycles, then RUN; a pending ex_branch_taken flushes in the following cycle.
REQ-039: mem_ack never asserted -> mem_timeout=1 after 255 MEM_WAIT cycles; asserting rst mid-wait clears everything asynchronously.
